// File: rtl/pipe_stage_skid.sv
// Two-entry FIFO pipeline stage (head + skid) between EX and MEM, with flush and scratch return.
// Latency 1 cycle; in_ready is registered and drops only when the skid entry is occupied.
module pipe_stage_skid #(
  parameter int DATA_W = 160,
  parameter int SCR_W  = 66
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SCR_W-1:0]  in_scr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SCR_W-1:0]  scr_o,
  output logic [1:0]        occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   head_q, head_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [SCR_W-1:0]    scr_q, scr_d;
  logic                rdy_q;
  logic                push;
  logic                pop;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = rdy_q;
  assign push      = in_valid & rdy_q;
  assign pop       = out_valid & out_ready;
  assign out_data  = head_q;
  assign scr_o     = scr_q;

  always_comb begin
    occ = 2'd0;
    case (state_q)
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      scr_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      scr_q   <= scr_d;
      // Registered from next state so out_ready never reaches in_ready combinationally.
      rdy_q   <= (state_d != FULL);
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    scr_d   = (flush || push) ? '0 : in_scr;

    if (flush) begin
      state_d = EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = in_data;
          end else if (push) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (pop) begin
            head_d  = '0;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d  = skid_q;
            skid_d  = '0;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed pushes queue expected payloads, a monitor checks pops.
module tb_pipe_stage_skid;

  localparam int DATA_W = 160;
  localparam int SCR_W  = 66;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [SCR_W-1:0]  in_scr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [SCR_W-1:0]  scr_o;
  logic [1:0]        occ;

  int checks;
  int errors;
  logic [DATA_W-1:0] expq[$];

  pipe_stage_skid #(.DATA_W(DATA_W), .SCR_W(SCR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_scr    (in_scr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .scr_o     (scr_o),
    .occ       (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake seen at the negedge completes at the following posedge.
  always @(negedge clk) begin
    if (rst && !flush && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no output", out_data);
      end else begin
        chk("pop_data", 256'(out_data), 256'(expq.pop_front()));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_scr    = '0;
    out_ready = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk("rst_occ",       256'(occ),       256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_in_ready",  256'(in_ready),  256'(0));
    chk("rst_out_data",  256'(out_data),  256'(0));
    chk("rst_scr",       256'(scr_o),     256'(0));
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_in_ready", 256'(in_ready), 256'(1));

    // Single transfer, one-cycle latency
    in_valid = 1'b1; in_data = DATA_W'(32'hA5); out_ready = 1'b1;
    expq.push_back(DATA_W'(32'hA5));
    tick();
    in_valid = 1'b0;
    chk("t1_out_valid", 256'(out_valid), 256'(1));
    chk("t1_out_data",  256'(out_data),  256'(32'hA5));
    chk("t1_occ",       256'(occ),       256'(1));
    tick();
    chk("t1_drain_occ", 256'(occ), 256'(0));

    // Fill under backpressure, third word held off, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DATA_W'(1); expq.push_back(DATA_W'(1));
    tick();
    chk("t2_occ1", 256'(occ), 256'(1));
    in_data = DATA_W'(2); expq.push_back(DATA_W'(2));
    tick();
    chk("t2_occ2",     256'(occ),      256'(2));
    chk("t2_in_ready", 256'(in_ready), 256'(0));
    in_data = DATA_W'(3);
    tick();
    chk("t2_hold_occ",  256'(occ),      256'(2));
    chk("t2_hold_head", 256'(out_data), 256'(1));
    out_ready = 1'b1;
    tick();
    chk("t2_ready_back", 256'(in_ready), 256'(1));
    expq.push_back(DATA_W'(3));
    tick();
    in_valid = 1'b0;
    chk("t2_head3", 256'(out_data), 256'(3));
    tick();
    chk("t2_empty", 256'(occ), 256'(0));

    // Flush while FULL drops held entries and the offered word
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DATA_W'(7); expq.push_back(DATA_W'(7));
    tick();
    in_data = DATA_W'(8); expq.push_back(DATA_W'(8));
    tick();
    in_valid = 1'b0; in_scr = SCR_W'(32'h3C);
    tick();
    chk("t3_full",    256'(occ),   256'(2));
    chk("t3_scr_pre", 256'(scr_o), 256'(32'h3C));
    flush = 1'b1; in_valid = 1'b1; in_data = DATA_W'(9); out_ready = 1'b1;
    expq.delete();
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("t3_occ",       256'(occ),       256'(0));
    chk("t3_out_valid", 256'(out_valid), 256'(0));
    chk("t3_out_data",  256'(out_data),  256'(0));
    chk("t3_scr",       256'(scr_o),     256'(0));
    tick();
    chk("t3_no_store", 256'(occ), 256'(0));

    // Scratch follows in_scr while idle, clears on push
    in_scr = SCR_W'(32'h155);
    tick();
    chk("t4_scr_155", 256'(scr_o), 256'(32'h155));
    in_scr = SCR_W'(32'h2AA);
    tick();
    chk("t4_scr_2aa", 256'(scr_o), 256'(32'h2AA));
    tick();
    chk("t4_scr_hold", 256'(scr_o), 256'(32'h2AA));
    in_valid = 1'b1; in_data = DATA_W'(32'h11); out_ready = 1'b1;
    expq.push_back(DATA_W'(32'h11));
    tick();
    chk("t4_scr_push", 256'(scr_o),    256'(0));
    chk("t4_head",     256'(out_data), 256'(32'h11));

    // Simultaneous push and pop in ONE
    in_data = DATA_W'(32'h42); expq.push_back(DATA_W'(32'h42));
    tick();
    in_valid = 1'b0;
    chk("t5_occ",      256'(occ),      256'(1));
    chk("t5_head",     256'(out_data), 256'(32'h42));
    chk("t5_in_ready", 256'(in_ready), 256'(1));
    tick();
    chk("t5_empty", 256'(occ), 256'(0));

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DATA_W'(32'h55); expq.push_back(DATA_W'(32'h55));
    tick();
    in_data = DATA_W'(32'h66); expq.push_back(DATA_W'(32'h66));
    tick();
    in_valid = 1'b0; in_scr = SCR_W'(7);
    tick();
    chk("t6_full", 256'(occ),   256'(2));
    chk("t6_scr",  256'(scr_o), 256'(7));
    #2;
    rst = 1'b0;
    expq.delete();
    #1;
    chk("t6_occ",       256'(occ),       256'(0));
    chk("t6_out_valid", 256'(out_valid), 256'(0));
    chk("t6_out_data",  256'(out_data),  256'(0));
    chk("t6_in_ready",  256'(in_ready),  256'(0));
    chk("t6_scr_zero",  256'(scr_o),     256'(0));
    tick();
    rst = 1'b1; in_scr = '0;
    tick();
    chk("t6_ready_again", 256'(in_ready), 256'(1));
    chk("t6_still_empty", 256'(occ),      256'(0));

    chk("scoreboard_drained", 256'(expq.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 160, meaning the width of the stage payload (dest reg, wdata, pc, hi/lo, cp0, except, aluop, addr fields concatenated).
REQ-002 The block SHALL have parameter SCR_W, default 66, meaning the width of the multicycle scratch bus (hilo + cnt).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  The single clock; all state updates on posedge.
REQ-005 rst  input  1  Asynchronous reset, active-low.
REQ-006 flush  input  1  Synchronous kill of all held entries (exception/eret).
REQ-007 in_valid  input  1  Producer (EX) offers in_data.
REQ-008 in_ready  output  1  Stage can accept; registered, equal to "skid entry empty".
REQ-009 in_data  input  DATA_W  Payload from EX.
REQ-010 in_scr  input  SCR_W  Multicycle scratch from EX.
REQ-011 out_valid  output  1  Head entry valid toward MEM.
REQ-012 out_ready  input  1  Consumer (MEM) accepts head.
REQ-013 out_data  output  DATA_W  Head payload; all-zero (NOP bubble) when out_valid=0.
REQ-014 scr_o  output  SCR_W  Scratch returned to EX.
REQ-015 occ  output  2  Entry count 0..2.

Function
REQ-016 Storage SHALL be two entries: head (drives out_data) and skid; order SHALL be FIFO.
REQ-017 push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at the same posedge.
REQ-018 States SHALL be EMPTY (occ=0), ONE (occ=1), FULL (occ=2).
REQ-019 EMPTY: push -> head<=in_data, ONE; else stay.
REQ-020 ONE: push&pop -> head<=in_data, stay ONE; push only -> skid<=in_data, FULL; pop only -> head<=0, EMPTY; neither -> hold.
REQ-021 FULL: pop -> head<=skid, skid<=0, ONE; no pop -> hold; push is impossible (in_ready=0).
REQ-022 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL; out_valid SHALL be 1 in ONE and FULL.
REQ-023 Latency SHALL be one cycle: data pushed at edge N is on out_data with out_valid=1 after edge N; sustained throughput SHALL be one transfer per cycle with out_ready held high.
REQ-024 flush SHALL take priority over push and pop: at the edge, head and skid <= 0, state <= EMPTY, scr_o <= 0; in_data offered that cycle is dropped.
REQ-025 Scratch: on an edge with flush or push, scr_o SHALL become 0; on any other edge scr_o SHALL become in_scr (carries multicycle hilo/cnt back to EX while EX is stalled).
REQ-026 Vacated entries SHALL be zeroed on the same edge they are vacated, never retaining stale payload.
REQ-027 No combinational path SHALL exist from out_ready to in_ready.

Reset
REQ-028 While rst=0, asynchronously: state EMPTY, occ=0, out_valid=0, in_ready=0, out_data=0, skid=0, scr_o=0.
REQ-029 On the first edge after rst deasserts, in_ready SHALL become 1; reset asserted mid-transfer SHALL discard all entries without completing any handshake.

Verification
REQ-030 Reset then in_valid=1, in_data=0xA5 (zero-extended), out_ready=1 -> out_valid=1, out_data=0xA5 after edge 1; occ=1.
REQ-031 Stream 0x1,0x2,0x3 on consecutive cycles, out_ready=0 from cycle 1 -> occ=2 after 0x1,0x2, in_ready=0; 0x3 held off; raise out_ready -> outputs 0x1,0x2,0x3 in order, no loss or duplicates.
REQ-032 FULL with heads 0x7,0x8; flush=1 with in_valid=1, in_data=0x9, out_ready=1 -> next cycle occ=0, out_valid=0, out_data=0, 0x9 not stored, scr_o=0.
REQ-033 No push for 3 cycles, in_scr=0x155 then 0x2AA -> scr_o follows in_scr one cycle later; push on next edge -> scr_o=0.
REQ-034 ONE state, push and pop same edge with in_data=0x42 -> occ stays 1, out_data=0x42, in_ready stays 1.
REQ-035 Assert rst=0 asynchronously between edges while FULL -> outputs zero immediately, before next posedge.
